// File: rtl/ccff_loader_pkg.sv
// ============================================================================
// Module   : ccff_loader_pkg
// Brief    : Shared state encoding and chain-size helpers for the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ccff_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SETUP  = 3'd2,
      PULSE  = 3'd3,
      EMIT   = 3'd4,
      FINISH = 3'd5
   } state_t;

   // Number of stream bytes needed to cover the whole chain.
   function automatic int nbytes(input int chain_len);
      return (chain_len + 7) / 8;
   endfunction

   // Bits used in the final byte; a full byte when the chain is a multiple of 8.
   function automatic int last_bits(input int chain_len);
      return ((chain_len % 8) == 0) ? 8 : (chain_len % 8);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_bit_serdes.sv
// ============================================================================
// Module   : ccff_bit_serdes
// Brief    : Byte-wide shift-out / capture-in pair indexed by a bit position.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_bit_serdes (
   input  logic       CK,
   input  logic       RN,
   input  logic       load,
   input  logic [7:0] din,
   input  logic       sample,
   input  logic       advance,
   input  logic       clear,
   input  logic       tail,
   output logic       head,
   output logic [7:0] rbreg,
   output logic [2:0] bitpos
);

   logic [7:0] r_shreg;
   logic [7:0] r_rbreg;
   logic [2:0] r_bitpos;
   logic       r_head;
   logic [2:0] w_bitpos_inc;

   assign w_bitpos_inc = r_bitpos + 3'd1;

   // head is pre-loaded with the next bit so it is already stable on entry to SETUP
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         r_shreg  <= 8'h00;
         r_rbreg  <= 8'h00;
         r_bitpos <= 3'd0;
         r_head   <= 1'b0;
      end else if (load) begin
         r_shreg  <= din;
         r_rbreg  <= 8'h00;
         r_bitpos <= 3'd0;
         r_head   <= din[0];
      end else begin
         if (sample) begin
            r_rbreg[r_bitpos] <= tail;
         end
         if (advance) begin
            r_bitpos <= w_bitpos_inc;
            r_head   <= r_shreg[w_bitpos_inc];
         end
         if (clear) begin
            r_head <= 1'b0;
         end
      end
   end

   assign head   = r_head;
   assign rbreg  = r_rbreg;
   assign bitpos = r_bitpos;

endmodule

`default_nettype wire

// File: rtl/ccff_chain_loader.sv
// ============================================================================
// Module   : ccff_chain_loader
// Brief    : Loads the fabric configuration chain from a byte stream and
//            returns the displaced chain contents as readback bytes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic       CK,
   input  logic       RN,
   input  logic       start,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       m_valid,
   output logic [7:0] m_data,
   input  logic       m_ready,
   output logic       ccff_head,
   output logic       prog_clk,
   input  logic       ccff_tail,
   output logic       busy,
   output logic       done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_bitcnt;
   logic [CNT_W-1:0] w_bitcnt_inc;
   logic             w_last_bit;
   logic             w_chain_full;
   logic             w_load;
   logic             w_sample;
   logic             w_advance;
   logic             w_clear;
   logic [7:0]       w_rbreg;
   logic [2:0]       w_bitpos;

   logic             r_s_ready;
   logic             r_m_valid;
   logic [7:0]       r_m_data;
   logic             r_prog_clk;
   logic             r_busy;
   logic             r_done;

   assign w_bitcnt_inc = r_bitcnt + CNT_W'(1);
   assign w_last_bit   = (w_bitcnt_inc == CNT_W'(CHAIN_LEN));
   assign w_chain_full = (r_bitcnt == CNT_W'(CHAIN_LEN));

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_sample    = 1'b0;
      w_advance   = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (s_valid) begin
               w_load      = 1'b1;
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            w_sample    = 1'b1;
            w_state_nxt = PULSE;
         end
         PULSE: begin
            w_advance = 1'b1;
            if (w_last_bit || (w_bitpos == 3'd7)) begin
               w_state_nxt = EMIT;
            end else begin
               w_state_nxt = SETUP;
            end
         end
         EMIT: begin
            if (m_ready) begin
               w_state_nxt = w_chain_full ? FINISH : FETCH;
            end
         end
         FINISH: begin
            w_clear     = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so each one is a plain flop that
   // tracks the state register cycle-for-cycle.
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         r_s_ready  <= 1'b0;
         r_m_valid  <= 1'b0;
         r_m_data   <= 8'h00;
         r_prog_clk <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bitcnt   <= '0;
      end else begin
         r_s_ready  <= (w_state_nxt == FETCH);
         r_m_valid  <= (w_state_nxt == EMIT);
         r_m_data   <= (w_state_nxt == EMIT) ? w_rbreg : 8'h00;
         r_prog_clk <= (w_state_nxt == PULSE);
         r_busy     <= (w_state_nxt == FETCH) || (w_state_nxt == SETUP) ||
                       (w_state_nxt == PULSE) || (w_state_nxt == EMIT);
         r_done     <= (w_state_nxt == FINISH);
         if ((r_state == IDLE) && start) begin
            r_bitcnt <= '0;
         end else if (r_state == PULSE) begin
            r_bitcnt <= w_bitcnt_inc;
         end
      end
   end

   ccff_bit_serdes u_serdes (
      .CK      (CK),
      .RN      (RN),
      .load    (w_load),
      .din     (s_data),
      .sample  (w_sample),
      .advance (w_advance),
      .clear   (w_clear),
      .tail    (ccff_tail),
      .head    (ccff_head),
      .rbreg   (w_rbreg),
      .bitpos  (w_bitpos)
   );

   assign s_ready  = r_s_ready;
   assign m_valid  = r_m_valid;
   assign m_data   = r_m_data;
   assign prog_clk = r_prog_clk;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ccff_chain_loader.sv
// ============================================================================
// Module   : tb_ccff_chain_loader
// Brief    : Directed bench driving an 8-flop and a 12-flop chain loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccff_chain_loader;

   logic            CK = 1'b0;
   logic            RN = 1'b1;
   logic [1:0]      start = '0;
   logic [1:0]      s_valid = '0;
   logic [1:0][7:0] s_data = '0;
   logic [1:0]      s_ready;
   logic [1:0]      m_valid;
   logic [1:0][7:0] m_data;
   logic [1:0]      m_ready = '0;
   logic [1:0]      ccff_head;
   logic [1:0]      prog_clk;
   logic [1:0]      ccff_tail;
   logic [1:0]      busy;
   logic [1:0]      done;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // Behavioural chains: head enters bit 0, tail leaves from the top bit.
   logic [7:0]  chain0 = 8'h00;
   logic [11:0] chain1 = 12'hFFF;
   logic [7:0]  hseq0 = 8'h00;
   int          pc0 = 0, pc1 = 0, dc0 = 0, dc1 = 0;

   ccff_chain_loader #(.CHAIN_LEN(8)) u_dut0 (
      .CK(CK), .RN(RN), .start(start[0]), .s_valid(s_valid[0]), .s_data(s_data[0]),
      .s_ready(s_ready[0]), .m_valid(m_valid[0]), .m_data(m_data[0]), .m_ready(m_ready[0]),
      .ccff_head(ccff_head[0]), .prog_clk(prog_clk[0]), .ccff_tail(ccff_tail[0]),
      .busy(busy[0]), .done(done[0])
   );

   ccff_chain_loader #(.CHAIN_LEN(12)) u_dut1 (
      .CK(CK), .RN(RN), .start(start[1]), .s_valid(s_valid[1]), .s_data(s_data[1]),
      .s_ready(s_ready[1]), .m_valid(m_valid[1]), .m_data(m_data[1]), .m_ready(m_ready[1]),
      .ccff_head(ccff_head[1]), .prog_clk(prog_clk[1]), .ccff_tail(ccff_tail[1]),
      .busy(busy[1]), .done(done[1])
   );

   always #5 CK = ~CK;
   always @(posedge CK) cyc <= cyc + 1;

   assign ccff_tail[0] = chain0[7];
   assign ccff_tail[1] = chain1[11];

   always @(posedge prog_clk[0]) begin
      chain0 <= {chain0[6:0], ccff_head[0]};
      hseq0  <= {hseq0[6:0], ccff_head[0]};
      pc0    <= pc0 + 1;
   end

   always @(posedge prog_clk[1]) begin
      chain1 <= {chain1[10:0], ccff_head[1]};
      pc1    <= pc1 + 1;
   end

   always @(posedge CK) begin
      if (done[0]) dc0 <= dc0 + 1;
      if (done[1]) dc1 <= dc1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] outs(input int u);
      return {s_ready[u], m_valid[u], m_data[u], ccff_head[u], prog_clk[u], busy[u], done[u]};
   endfunction

   function automatic int get_pc(input int u);
      return (u == 0) ? pc0 : pc1;
   endfunction

   function automatic int get_dc(input int u);
      return (u == 0) ? dc0 : dc1;
   endfunction

   task automatic run_load(input int u, input int nb, input int len,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input bit chk_rb, input bit stall, input bit stray,
                           input int exp_lat);
      int          pc_s, dc_s, t0, to;
      logic        ok, h;
      @(negedge CK);
      pc_s       = get_pc(u);
      dc_s       = get_dc(u);
      t0         = cyc;
      start[u]   = 1'b1;
      s_valid[u] = 1'b1;
      s_data[u]  = b0;
      m_ready[u] = !stall;
      @(negedge CK);
      start[u] = 1'b0;
      chk("busy_after_start", busy[u], 1'b1);
      for (int i = 0; i < nb; i++) begin
         s_valid[u] = 1'b1;
         s_data[u]  = (i == 0) ? b0 : b1;
         to = 0;
         while (!s_ready[u] && to < 50) begin
            @(negedge CK);
            to++;
         end
         chk("s_ready_wait", (to < 50), 1'b1);
         @(negedge CK);
         s_valid[u] = 1'b0;
         if (stray && i == 0) begin
            start[u] = 1'b1;
            @(negedge CK);
            start[u] = 1'b0;
         end
         to = 0;
         while (!m_valid[u] && to < 100) begin
            @(negedge CK);
            to++;
         end
         chk("m_valid_wait", (to < 100), 1'b1);
         if (chk_rb) chk((i == 0) ? "rb_byte0" : "rb_byte1", m_data[u], (i == 0) ? e0 : e1);
         if (stall) begin
            ok = 1'b1;
            h  = ccff_head[u];
            repeat (10) begin
               @(negedge CK);
               if (prog_clk[u] !== 1'b0 || ccff_head[u] !== h || m_valid[u] !== 1'b1) ok = 1'b0;
            end
            chk("stall_hold", ok, 1'b1);
            m_ready[u] = 1'b1;
         end
      end
      to = 0;
      while (!done[u] && to < 50) begin
         @(negedge CK);
         to++;
      end
      chk("done_wait", (to < 50), 1'b1);
      if (exp_lat != 0) chk("latency", cyc - t0, exp_lat);
      chk("prog_clk_pulses", get_pc(u) - pc_s, len);
      @(negedge CK);
      chk("done_one_cycle", done[u], 1'b0);
      chk("busy_cleared", busy[u], 1'b0);
      repeat (2) @(negedge CK);
      chk("done_count", get_dc(u) - dc_s, 1);
   endtask

   initial begin
      int p, to;
      #1 RN = 1'b0;
      repeat (3) @(negedge CK);
      chk("reset_outs0", outs(0), 15'h0);
      chk("reset_outs1", outs(1), 15'h0);
      RN = 1'b1;
      repeat (2) @(negedge CK);
      chk("idle_outs0", outs(0), 15'h0);

      // 8-flop chain: A5 into a cleared chain, then 3C with readback backpressure
      run_load(0, 1, 8, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 19);
      chk("head_seq_a5", hseq0, 8'hA5);
      chk("chain0_a5", chain0, 8'hA5);
      run_load(0, 1, 8, 8'h3C, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 0);
      chk("chain0_3c", chain0, 8'h3C);

      // 12-flop chain: partial last byte, ignored high data bits, stray start
      run_load(1, 2, 12, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 1'b1, 1'b0, 1'b0, 29);
      chk("chain1_fff", chain1, 12'hFFF);
      run_load(1, 2, 12, 8'h34, 8'hFA, 8'hFF, 8'h0F, 1'b1, 1'b0, 1'b1, 29);
      chk("chain1_2c5", chain1, 12'h2C5);
      run_load(1, 2, 12, 8'h00, 8'h00, 8'h34, 8'h0A, 1'b1, 1'b0, 1'b0, 29);
      chk("chain1_000", chain1, 12'h000);

      // Abort in SETUP of bit 5, then reload from bit 0
      @(negedge CK);
      p          = pc0;
      start[0]   = 1'b1;
      s_valid[0] = 1'b1;
      s_data[0]  = 8'h3C;
      m_ready[0] = 1'b1;
      @(negedge CK);
      start[0] = 1'b0;
      @(negedge CK);
      s_valid[0] = 1'b0;
      to = 0;
      while (!((pc0 - p) == 5 && prog_clk[0] == 1'b0) && to < 100) begin
         @(negedge CK);
         to++;
      end
      chk("bit5_wait", (to < 100), 1'b1);
      chk("head_bit5", ccff_head[0], 1'b1);
      #2 RN = 1'b0;
      #1 chk("async_reset_outs", outs(0), 15'h0);
      @(negedge CK);
      RN = 1'b1;
      @(negedge CK);
      chk("post_reset_outs", outs(0), 15'h0);
      run_load(0, 1, 8, 8'h96, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 19);
      chk("chain0_96", chain0, 8'h69);
      run_load(0, 1, 8, 8'h00, 8'h00, 8'h96, 8'h00, 1'b1, 1'b0, 1'b0, 19);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
